leve2_csr_trap: RTL

LEVE2_CSR_TRAP -- requirements
Module: leve2_csr_trap

---
 rtl/leve2_csr_trap.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/leve2_csr_trap.sv
// leve2_csr_trap
//   Machine/supervisor CSR file with trap entry, xRET handling and optional
//   cycle/instret counters.
//
//   Optional feature macro: LEVE_CSR_COUNTERS_EN
//     defined   -> mcycle/minstret (0xB00/0xB02) and cycle/instret
//                  (0xC00/0xC02) are real counters
//     undefined -> those addresses read 0, writes are silently ignored and
//                  RETIRE has no effect
//
//   Ports
//     CLK, RST          clock, synchronous active-high reset
//     CSR_RA / CSR_RD   read address / registered read data (one-cycle latency)
//     CSR_WCMD          0 none, 1 write, 2 set, 3 clear
//     CSR_WA / CSR_WD   write address / write data
//     CSR_ILL           combinational: current write command is illegal
//     RETIRE            one instruction retired this cycle
//     TRAP, TRAP_CAUSE, TRAP_VAL, TRAP_EPC   trap request and details
//     MRET, SRET        return requests
//     NEXT_PC           combinational redirect target (0 when no event)
//     MODE              current privilege (3=M, 1=S, 0=U)
//     MSTATUS           combinational mstatus view
module leve2_csr_trap #(
   parameter int          XLEN         = 64,
   parameter int          HARTID       = 0,
   parameter logic [63:0] MEDELEG_MASK = 64'hB3FF
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [11:0]     CSR_RA,
   output logic [XLEN-1:0] CSR_RD,
   input  logic [1:0]      CSR_WCMD,
   input  logic [11:0]     CSR_WA,
   input  logic [XLEN-1:0] CSR_WD,
   output logic            CSR_ILL,
   input  logic            RETIRE,
   input  logic            TRAP,
   input  logic [XLEN-1:0] TRAP_CAUSE,
   input  logic [XLEN-1:0] TRAP_VAL,
   input  logic [XLEN-1:0] TRAP_EPC,
   input  logic            MRET,
   input  logic            SRET,
   output logic [XLEN-1:0] NEXT_PC,
   output logic [1:0]      MODE,
   output logic [XLEN-1:0] MSTATUS
);

   // UXL/SXL are hard-wired to 2 (64-bit) and only exist on RV64.
   localparam logic [63:0] XL_FIELDS     = (XLEN == 64) ? 64'h0000_000A_0000_0000 : 64'h0;
   // sstatus shows SIE, SPIE, SPP, SUM, MXR and UXL.
   localparam logic [63:0] SSTATUS_RMASK = (XLEN == 64) ? 64'h0000_0003_000C_0122 : 64'h0000_0000_000C_0122;

   logic [1:0]      mode_reg;
   logic            sie_reg, mie_reg, spie_reg, mpie_reg, spp_reg;
   logic            mprv_reg, sum_reg, mxr_reg;
   logic [1:0]      mpp_reg;
   logic [7:0]      fcsr_reg;
   logic [XLEN-1:0] stvec_reg, sepc_reg, scause_reg, stval_reg, satp_reg;
   logic [XLEN-1:0] medeleg_reg, mtvec_reg, mepc_reg, mcause_reg, mtval_reg;
   logic [XLEN-1:0] csr_rd_reg;

   logic [XLEN-1:0] mstatus_view;
   logic [XLEN:0]   rd_lookup, wr_lookup;
   logic [XLEN-1:0] wr_old, wr_new, next_pc;
   logic            wr_illegal, wr_en, trap_deleg;
   logic [63:0]     medeleg_ext;

`ifdef LEVE_CSR_COUNTERS_EN
   logic [XLEN-1:0] mcycle_reg, minstret_reg;
`else
   logic            unused_retire;
   assign unused_retire = RETIRE;
`endif

   always_comb begin
      mstatus_view       = XL_FIELDS[XLEN-1:0];
      mstatus_view[1]    = sie_reg;
      mstatus_view[3]    = mie_reg;
      mstatus_view[5]    = spie_reg;
      mstatus_view[7]    = mpie_reg;
      mstatus_view[8]    = spp_reg;
      mstatus_view[12:11] = mpp_reg;
      mstatus_view[17]   = mprv_reg;
      mstatus_view[18]   = sum_reg;
      mstatus_view[19]   = mxr_reg;
   end

   // Returns {implemented, value} for a CSR address.
   function automatic logic [XLEN:0] csr_lookup(input logic [11:0] addr);
      logic [XLEN-1:0] v;
      logic            hit;
      v   = '0;
      hit = 1'b1;
      case (addr)
         12'h001: v[4:0] = fcsr_reg[4:0];
         12'h002: v[2:0] = fcsr_reg[7:5];
         12'h003: v[7:0] = fcsr_reg;
         12'h100: v = mstatus_view & SSTATUS_RMASK[XLEN-1:0];
         12'h105: v = stvec_reg;
         12'h141: v = sepc_reg;
         12'h142: v = scause_reg;
         12'h143: v = stval_reg;
         12'h180: v = satp_reg;
         12'h300: v = mstatus_view;
         12'h302: v = medeleg_reg;
         12'h305: v = mtvec_reg;
         12'h341: v = mepc_reg;
         12'h342: v = mcause_reg;
         12'h343: v = mtval_reg;
         12'hF11, 12'hF12, 12'hF13: v = '0;
         12'hF14: v = XLEN'(HARTID);
`ifdef LEVE_CSR_COUNTERS_EN
         12'hB00, 12'hC00: v = mcycle_reg;
         12'hB02, 12'hC02: v = minstret_reg;
`else
         12'hB00, 12'hB02, 12'hC00, 12'hC02: v = '0;
`endif
         default: hit = 1'b0;
      endcase
      return {hit, v};
   endfunction

   always_comb begin
      rd_lookup = csr_lookup(CSR_RA);
      wr_lookup = csr_lookup(CSR_WA);
      wr_old    = wr_lookup[XLEN-1:0];
      case (CSR_WCMD)
         2'd1:    wr_new = CSR_WD;
         2'd2:    wr_new = wr_old | CSR_WD;
         2'd3:    wr_new = wr_old & ~CSR_WD;
         default: wr_new = wr_old;
      endcase
      wr_illegal = (CSR_WCMD != 2'd0) &&
                   ((CSR_WA[11:10] == 2'b11) || (CSR_WA[9:8] > mode_reg) || !wr_lookup[XLEN]);
      // A trap or xRET in the same cycle drops the write entirely.
      wr_en = (CSR_WCMD != 2'd0) && !wr_illegal && !TRAP && !MRET && !SRET;

      medeleg_ext             = '0;
      medeleg_ext[XLEN-1:0]   = medeleg_reg;
      trap_deleg = (mode_reg <= 2'd1) && medeleg_ext[TRAP_CAUSE[5:0]] && !TRAP_CAUSE[XLEN-1];

      if (TRAP)      next_pc = trap_deleg ? stvec_reg : mtvec_reg;
      else if (MRET) next_pc = mepc_reg;
      else if (SRET) next_pc = sepc_reg;
      else           next_pc = '0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         mode_reg    <= 2'd3;
         mpp_reg     <= 2'd3;
         sie_reg     <= 1'b0;
         mie_reg     <= 1'b0;
         spie_reg    <= 1'b0;
         mpie_reg    <= 1'b0;
         spp_reg     <= 1'b0;
         mprv_reg    <= 1'b0;
         sum_reg     <= 1'b0;
         mxr_reg     <= 1'b0;
         fcsr_reg    <= '0;
         stvec_reg   <= '0;
         sepc_reg    <= '0;
         scause_reg  <= '0;
         stval_reg   <= '0;
         satp_reg    <= '0;
         medeleg_reg <= '0;
         mtvec_reg   <= '0;
         mepc_reg    <= '0;
         mcause_reg  <= '0;
         mtval_reg   <= '0;
         csr_rd_reg  <= '0;
      end else begin
         // Read samples pre-edge state, so a same-cycle write is not forwarded.
         csr_rd_reg <= rd_lookup[XLEN] ? rd_lookup[XLEN-1:0] : '0;
         if (TRAP) begin
            if (trap_deleg) begin
               sepc_reg   <= TRAP_EPC;
               scause_reg <= TRAP_CAUSE;
               stval_reg  <= TRAP_VAL;
               spp_reg    <= mode_reg[0];
               spie_reg   <= sie_reg;
               sie_reg    <= 1'b0;
               mode_reg   <= 2'd1;
            end else begin
               mepc_reg   <= TRAP_EPC;
               mcause_reg <= TRAP_CAUSE;
               mtval_reg  <= TRAP_VAL;
               mpp_reg    <= mode_reg;
               mpie_reg   <= mie_reg;
               mie_reg    <= 1'b0;
               mode_reg   <= 2'd3;
            end
         end else if (MRET) begin
            mode_reg <= mpp_reg;
            mie_reg  <= mpie_reg;
            mpie_reg <= 1'b1;
            mpp_reg  <= 2'd0;
            if (mpp_reg != 2'd3) mprv_reg <= 1'b0;
         end else if (SRET) begin
            mode_reg <= {1'b0, spp_reg};
            sie_reg  <= spie_reg;
            spie_reg <= 1'b1;
            spp_reg  <= 1'b0;
         end else if (wr_en) begin
            case (CSR_WA)
               12'h001: fcsr_reg[4:0] <= wr_new[4:0];
               12'h002: fcsr_reg[7:5] <= wr_new[2:0];
               12'h003: fcsr_reg      <= wr_new[7:0];
               12'h100: begin
                  sie_reg  <= wr_new[1];
                  spie_reg <= wr_new[5];
                  spp_reg  <= wr_new[8];
                  sum_reg  <= wr_new[18];
                  mxr_reg  <= wr_new[19];
               end
               12'h105: stvec_reg  <= {wr_new[XLEN-1:2], 2'b00};
               12'h141: sepc_reg   <= {wr_new[XLEN-1:1], 1'b0};
               12'h142: scause_reg <= wr_new;
               12'h143: stval_reg  <= wr_new;
               12'h180: satp_reg   <= wr_new;
               12'h300: begin
                  sie_reg  <= wr_new[1];
                  mie_reg  <= wr_new[3];
                  spie_reg <= wr_new[5];
                  mpie_reg <= wr_new[7];
                  spp_reg  <= wr_new[8];
                  // MPP=2 is a reserved privilege; keep the previous legal value.
                  if (wr_new[12:11] != 2'b10) mpp_reg <= wr_new[12:11];
                  mprv_reg <= wr_new[17];
                  sum_reg  <= wr_new[18];
                  mxr_reg  <= wr_new[19];
               end
               12'h302: medeleg_reg <= wr_new & MEDELEG_MASK[XLEN-1:0];
               12'h305: mtvec_reg   <= {wr_new[XLEN-1:2], 2'b00};
               12'h341: mepc_reg    <= {wr_new[XLEN-1:1], 1'b0};
               12'h342: mcause_reg  <= wr_new;
               12'h343: mtval_reg   <= wr_new;
               default: ;
            endcase
         end
      end
   end

`ifdef LEVE_CSR_COUNTERS_EN
   // An explicit write wins over the increment in the same cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         mcycle_reg   <= '0;
         minstret_reg <= '0;
      end else begin
         if (wr_en && (CSR_WA == 12'hB00)) mcycle_reg <= wr_new;
         else                              mcycle_reg <= mcycle_reg + XLEN'(1);
         if (wr_en && (CSR_WA == 12'hB02)) minstret_reg <= wr_new;
         else if (RETIRE)                  minstret_reg <= minstret_reg + XLEN'(1);
      end
   end
`endif

   assign CSR_RD  = csr_rd_reg;
   assign CSR_ILL = wr_illegal;
   assign NEXT_PC = next_pc;
   assign MODE    = mode_reg;
   assign MSTATUS = mstatus_view;

endmodule
